mips_prog_loader: RTL and testbench
===================================

# mips_prog_loader

Boot-time program loader for the multicycle MIPS core. Accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit instruction words, and writes them into the unified instruction/data memory at word-aligned byte addresses 0x0, 0x4, 0x8, …. It holds the core in reset (`cpu_rst`) until the whole program is in memory, then releases it. It replaces bench-side forcing of memory contents, so the core executes exactly what was written.

## Interface
- `mem_width`, 32, memory word width; fixed at 32 for byte packing.
- `mem_add_width`, 32, width of `mem_addr`.
- `mem_depth`, 256, number of byte-addressed memory entries; last legal word address is `mem_depth-4`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  program byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies the final byte of the stream.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  `mem_add_width`  byte address of the write, always a multiple of 4.
- `mem_wdata`  out  `mem_width`  packed instruction word.
- `cpu_rst`  out  1  active-high reset to the core.
- `done`  out  1  load complete; sticky until `rst`.
- `err`  out  1  load failed; sticky until `rst`.

## Operation
- States: LOAD, WRITE, DONE, ERR. Reset enters LOAD with byte count 0, word register 0, and next address 0.
- LOAD: `in_ready`=1. A byte is accepted on an edge where `in_valid && in_ready`.
  - Byte k of a word (k=0..3) goes to bits [31-8k : 24-8k], so the first byte is the MSB.
- A word is complete when either of these holds:
  - the 4th byte is accepted;
  - a byte with `in_last`=1 is accepted. Unfilled low bytes are then zero.
- On word completion, the next state depends on the address:
  - Next address ≤ `mem_depth-4`: go to WRITE.
  - Otherwise: go to ERR and issue no write.
- WRITE (exactly 1 cycle): `mem_we`=1, `mem_addr`=current address, `mem_wdata`=word. `in_ready`=0. The address then advances by 4 and the byte count clears.
  - If the word was closed by `in_last`: go to DONE.
  - Otherwise: go to LOAD.
- DONE: `cpu_rst`=0, `done`=1, `in_ready`=0. Holds until `rst`.
- ERR: `cpu_rst`=1, `err`=1, `in_ready`=0. Holds until `rst`.
- `cpu_rst`=1 in every state except DONE.
- `in_data`/`in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- `mem_addr`/`mem_wdata` hold their last written values outside WRITE.

## Timing
- Reset values while `rst`=1:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0.
  - `in_ready` rises on the first `clk` edge after `rst` falls.
- All outputs are registered.
- `mem_we` asserts the cycle after the edge that accepts the completing byte.
- `cpu_rst` falls, and `done` rises, the cycle after the final `mem_we` cycle.
- Throughput: 4 bytes per 5 cycles maximum, because `in_ready` drops for the WRITE cycle.
- `rst` asserted mid-load or mid-WRITE aborts immediately:
  - any in-progress `mem_we` drops asynchronously;
  - the partial word is discarded;
  - the next load restarts at address 0.
- `in_last` on the 4th byte of a word produces a single write, with no extra padded word.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The byte carrying `in_last` is a checksum, not program data. It never enters a word.
  - The loader keeps a mod-256 sum of all data bytes.
  - At `in_last`: if a partial word is pending, it is zero-padded and written first.
  - Then, if (sum + checksum) mod 256 = 0, go to DONE. Otherwise go to ERR; words already written stay in memory.
  - A stream consisting only of a checksum byte 0x00 reaches DONE with no writes.
- Undefined: no checksum logic. The `in_last` byte is ordinary data, as described above.

## Test plan
- Bytes 20 02 00 05, 20 03 00 0C with `in_last` on 0C:
  - writes 0x20020005 @0x0, then 0x2003000C @0x4;
  - `done`=1 and `cpu_rst`=0 one cycle after the second write.
- Bytes AB CD with `in_last` on CD: single write 0xABCD0000 @0x0, then DONE.
- `mem_depth`=16, 20 bytes streamed:
  - four writes @0x0–0xC;
  - the 5th word raises `err`=1 with no 5th `mem_we`;
  - `cpu_rst` stays 1.
- `in_valid` toggled randomly with gaps, 8 bytes: same two words as gap-free streaming; `in_ready`=0 during each WRITE cycle.
- `rst` pulsed after 6 bytes, then 4 fresh bytes 11 22 33 44 with last: single write 0x11223344 @0x0.
- `LOADER_CHECKSUM_EN` variants, data 01 02 03 04:
  - checksum 0xF6: `done`=1;
  - checksum 0xF7: `err`=1, with word 0x01020304 already written.

Source files
------------

// File: rtl/mips_prog_loader.sv
// mips_prog_loader
//   Boot-time program loader for the multicycle MIPS core. Packs an incoming
//   byte stream big-endian into 32-bit words and writes them to memory at
//   byte addresses 0x0, 0x4, 0x8, ... . The core is held in reset until the
//   whole program has been written.
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   in_data/in_valid/in_last/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata           one-cycle memory write port
//   cpu_rst           reset to the core, released only in DONE
//   done / err        sticky completion / failure flags
//
// Configuration
//   LOADER_CHECKSUM_EN : the in_last byte is a mod-256 checksum over all data
//                        bytes instead of program data. Undefined by default.
module mips_prog_loader #(
  parameter int mem_width     = 32,
  parameter int mem_add_width = 32,
  parameter int mem_depth     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [mem_add_width-1:0] mem_addr,
  output logic [mem_width-1:0]     mem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {LOAD, WRITE, DONE, ERR} state_t;

  localparam logic [mem_add_width-1:0] LAST_ADDR = mem_add_width'(mem_depth - 4);
  localparam logic [mem_add_width-1:0] WORD_STEP = mem_add_width'(4);

  state_t                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [mem_width-1:0]     word_q, word_d;
  logic [mem_add_width-1:0] addr_q, addr_d;
  logic                     last_q, last_d;
  logic                     in_ready_q, in_ready_d;
  logic                     mem_we_q, mem_we_d;
  logic [mem_add_width-1:0] mem_addr_q, mem_addr_d;
  logic [mem_width-1:0]     mem_wdata_q, mem_wdata_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               sum_q, sum_d;
  logic                     ok_q, ok_d;
`endif

  logic                 accept;
  logic                 addr_ok;
  logic [mem_width-1:0] word_new;

  assign accept  = (state_q == LOAD) && in_valid && in_ready_q;
  assign addr_ok = (addr_q <= LAST_ADDR);
  // Byte k of a word lands at bits [31-8k : 24-8k]: first byte is the MSB.
  assign word_new = word_q | ({in_data, {(mem_width-8){1'b0}}} >> {cnt_q, 3'b000});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    addr_d      = addr_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    ok_d        = ok_q;
`endif

    case (state_q)
      LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (in_last) begin
            // Checksum byte: never packed. Flush any partial word first.
            ok_d   = ((sum_q + in_data) == 8'h00);
            last_d = 1'b1;
            cnt_d  = 2'd0;
            word_d = '0;
            if (cnt_q != 2'd0) begin
              if (addr_ok) begin
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = word_q;
              end else begin
                state_d = ERR;
              end
            end else begin
              state_d = ((sum_q + in_data) == 8'h00) ? DONE : ERR;
            end
          end else begin
            sum_d = sum_q + in_data;
            if (cnt_q == 2'd3) begin
              cnt_d  = 2'd0;
              word_d = '0;
              last_d = 1'b0;
              if (addr_ok) begin
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = word_new;
              end else begin
                state_d = ERR;
              end
            end else begin
              cnt_d  = cnt_q + 2'd1;
              word_d = word_new;
            end
          end
`else
          if (cnt_q == 2'd3 || in_last) begin
            // Word closed; unfilled low bytes of word_new are already zero.
            cnt_d  = 2'd0;
            word_d = '0;
            last_d = in_last;
            if (addr_ok) begin
              state_d     = WRITE;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = word_new;
            end else begin
              state_d = ERR;
            end
          end else begin
            cnt_d  = cnt_q + 2'd1;
            word_d = word_new;
          end
`endif
        end
      end
      WRITE: begin
        addr_d = addr_q + WORD_STEP;
        cnt_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
        state_d = last_q ? (ok_q ? DONE : ERR) : LOAD;
`else
        state_d = last_q ? DONE : LOAD;
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = ERR;
    endcase

    // Outputs are registered copies of the next-state decode.
    in_ready_d = (state_d == LOAD);
    cpu_rst_d  = (state_d != DONE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= 2'd0;
      word_q      <= '0;
      addr_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
      ok_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      ok_q        <= ok_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader. dut drives the default 256-byte
// memory map; dut2 has a 16-byte map for the overflow case. A negedge
// monitor records every write for later comparison.
module tb_mips_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        sel2 = 1'b0;

  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic        in_ready2, mem_we2, cpu_rst2, done2, err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic        rdy;

  always #5 clk = ~clk;

  mips_prog_loader #(.mem_width(32), .mem_add_width(32), .mem_depth(256)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & ~sel2),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err));

  mips_prog_loader #(.mem_width(32), .mem_add_width(32), .mem_depth(16)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & sel2),
    .in_last(in_last), .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_rst(cpu_rst2), .done(done2), .err(err2));

  assign rdy = sel2 ? in_ready2 : in_ready;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_cyc = -1;
  int rdy_viol = 0;
  logic [31:0] wq_a[$], wq_d[$];
  int          wq_c[$];
  logic [31:0] w2_a[$], w2_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      wq_a.delete(); wq_d.delete(); wq_c.delete();
      w2_a.delete(); w2_d.delete();
      done_cyc = -1;
      rdy_viol = 0;
    end else begin
      if (mem_we) begin
        wq_a.push_back(mem_addr); wq_d.push_back(mem_wdata); wq_c.push_back(cyc);
        if (in_ready) rdy_viol++;
      end
      if (mem_we2) begin
        w2_a.push_back(mem_addr2); w2_d.push_back(mem_wdata2);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    while (!rdy && n < 100) begin @(negedge clk); n++; end
    if (!rdy) chk("ready_timeout", {31'b0, rdy}, 32'd1);
    else begin
      in_data = b; in_last = l; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_end(input bit two);
    int n = 0;
    while (!(two ? (done2 | err2) : (done | err)) && n < 200) begin @(negedge clk); n++; end
    chk("end_timeout", {31'b0, two ? (done2 | err2) : (done | err)}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] t1 [8];
    t1 = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};

    // Reset values
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_wdata",    mem_wdata,         32'd0);
    chk("rst_cpu_rst",  {31'b0, cpu_rst},  32'd1);
    chk("rst_done",     {31'b0, done},     32'd0);
    chk("rst_err",      {31'b0, err},      32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 01+02+03+04 = 0x0A, 0x0A + 0xF6 = 0x100
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'hF6, 1);
    wait_end(0);
    chk("cs_ok_nwr",  wq_d.size(), 32'd1);
    chk("cs_ok_data", wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h01020304);
    chk("cs_ok_done", {31'b0, done}, 32'd1);
    chk("cs_ok_err",  {31'b0, err},  32'd0);
    chk("cs_ok_crst", {31'b0, cpu_rst}, 32'd0);

    do_reset();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'hF7, 1);
    wait_end(0);
    chk("cs_bad_nwr",  wq_d.size(), 32'd1);
    chk("cs_bad_data", wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h01020304);
    chk("cs_bad_err",  {31'b0, err},  32'd1);
    chk("cs_bad_done", {31'b0, done}, 32'd0);
    chk("cs_bad_crst", {31'b0, cpu_rst}, 32'd1);

    do_reset();
    send(8'h00, 1);
    wait_end(0);
    chk("cs_only_nwr",  wq_d.size(), 32'd0);
    chk("cs_only_done", {31'b0, done}, 32'd1);

    // Partial word flushed before the checksum: AB CD + 0x88 (0x178 -> 0x78)... use 0x88
    do_reset();
    send(8'hAB, 0); send(8'hCD, 0); send(8'h88, 1);
    wait_end(0);
    chk("cs_pad_nwr",  wq_d.size(), 32'd1);
    chk("cs_pad_data", wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'hABCD0000);
    chk("cs_pad_done", {31'b0, done}, 32'd1);
`else
    // Two full words, last on the 8th byte
    foreach (t1[i]) send(t1[i], i == 7);
    wait_end(0);
    chk("t1_nwr",   wq_d.size(), 32'd2);
    chk("t1_a0",    wq_a.size() > 0 ? wq_a[0] : 32'hX, 32'h0);
    chk("t1_d0",    wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h20020005);
    chk("t1_a1",    wq_a.size() > 1 ? wq_a[1] : 32'hX, 32'h4);
    chk("t1_d1",    wq_d.size() > 1 ? wq_d[1] : 32'hX, 32'h2003000C);
    chk("t1_done",  {31'b0, done},    32'd1);
    chk("t1_crst",  {31'b0, cpu_rst}, 32'd0);
    chk("t1_done_lat", done_cyc, wq_c.size() > 1 ? wq_c[1] + 1 : -5);
    chk("t1_rdy_in_write", rdy_viol, 32'd0);

    // Partial word closed by in_last
    do_reset();
    send(8'hAB, 0); send(8'hCD, 1);
    wait_end(0);
    chk("t2_nwr",  wq_d.size(), 32'd1);
    chk("t2_a0",   wq_a.size() > 0 ? wq_a[0] : 32'hX, 32'h0);
    chk("t2_d0",   wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'hABCD0000);
    chk("t2_done", {31'b0, done}, 32'd1);

    // 16-byte memory, 20 bytes: fifth word overflows
    do_reset();
    sel2 = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i + 1), i == 19);
    wait_end(1);
    chk("t3_nwr",  w2_d.size(), 32'd4);
    chk("t3_a3",   w2_a.size() > 3 ? w2_a[3] : 32'hX, 32'hC);
    chk("t3_d3",   w2_d.size() > 3 ? w2_d[3] : 32'hX, 32'h0D0E0F10);
    chk("t3_err",  {31'b0, err2},     32'd1);
    chk("t3_done", {31'b0, done2},    32'd0);
    chk("t3_crst", {31'b0, cpu_rst2}, 32'd1);
    sel2 = 1'b0;

    // Random gaps; junk on in_data/in_last while in_valid is low
    do_reset();
    foreach (t1[i]) begin
      in_data = 8'hEE; in_last = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(t1[i], i == 7);
    end
    wait_end(0);
    chk("t4_nwr", wq_d.size(), 32'd2);
    chk("t4_d0",  wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h20020005);
    chk("t4_d1",  wq_d.size() > 1 ? wq_d[1] : 32'hX, 32'h2003000C);
    chk("t4_a1",  wq_a.size() > 1 ? wq_a[1] : 32'hX, 32'h4);
    chk("t4_rdy_in_write", rdy_viol, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd1);

    // Reset during WRITE drops mem_we asynchronously
    do_reset();
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    chk("t5_we_before", {31'b0, mem_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_we_async", {31'b0, mem_we},   32'd0);
    chk("t5_rdy_rst",  {31'b0, in_ready}, 32'd0);
    chk("t5_crst_rst", {31'b0, cpu_rst},  32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    // Reset after 6 bytes, then a fresh single word
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 0);
    do_reset();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    wait_end(0);
    chk("t5_nwr",  wq_d.size(), 32'd1);
    chk("t5_a0",   wq_a.size() > 0 ? wq_a[0] : 32'hX, 32'h0);
    chk("t5_d0",   wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h11223344);
    chk("t5_done", {31'b0, done}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
